mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all ports.
REQ-002 Parameter DATA_W, default 32, data width of all ports; byte-enable width is DATA_W/8.
REQ-003 Parameter STARVE_MAX, default 4, consecutive LS grants allowed while IF waits.
REQ-004 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 if_req  in  1  fetch request, held with if_addr stable until if_gnt.
REQ-007 if_addr  in  ADDR_W  fetch address.
REQ-008 if_gnt  out  1  fetch request accepted this cycle.
REQ-009 if_rvalid  out  1  fetch read data valid.
REQ-010 if_rdata  out  DATA_W  fetch read data.
REQ-011 ls_req  in  1  load/store request, held with ls_we/ls_be/ls_addr/ls_wdata stable until ls_gnt.
REQ-012 ls_we  in  1  1 = store, 0 = load.
REQ-013 ls_be  in  DATA_W/8  store byte enables.
REQ-014 ls_addr  in  ADDR_W  load/store address.
REQ-015 ls_wdata  in  DATA_W  store data.
REQ-016 ls_gnt  out  1  load/store request accepted this cycle.
REQ-017 ls_rvalid  out  1  load data valid, or store acknowledge.
REQ-018 ls_rdata  out  DATA_W  load data.
REQ-019 mem_req / mem_we / mem_be / mem_addr / mem_wdata  out  1/1/DATA_W/8/ADDR_W/DATA_W  downstream single-port memory request.
REQ-020 mem_gnt  in  1  memory accepted the request.
REQ-021 mem_rvalid  in  1  memory response; one per accepted request, loads and stores alike.
REQ-022 mem_rdata  in  DATA_W  memory read data.
REQ-023 busy  out  1  high in any state other than IDLE.
REQ-024 proto_err  out  1  sticky flag for a protocol violation by the memory.

Function
REQ-025 The FSM SHALL have three states: IDLE, REQ and WAIT, with at most one outstanding memory transaction.
REQ-026 IDLE: if any request is pending, arbitrate, register the owner and its request fields, and go to REQ; otherwise stay.
REQ-027 Arbitration: LS wins, except that IF wins when if_req=1 and the starve counter equals STARVE_MAX.
REQ-028 Starve counter: +1 on each LS win while if_req=1; cleared on an IF win or when if_req=0 at arbitration; saturates at STARVE_MAX.
REQ-029 REQ: mem_req=1 and mem_* SHALL be driven from the registered fields; on mem_gnt=1 go to WAIT, otherwise hold with the fields unchanged.
REQ-030 The owner's gnt SHALL be mem_gnt AND state==REQ AND owner match; the non-owner's gnt SHALL be 0.
REQ-031 WAIT: the owner's rvalid SHALL equal mem_rvalid, combinationally, and its rdata SHALL equal mem_rdata.
REQ-032 Outside of a valid response, rdata SHALL be 0 for both ports, and the non-owner's rvalid SHALL always be 0.
REQ-033 WAIT with mem_rvalid=1: if a request is pending, arbitrate and go directly to REQ (back-to-back); otherwise go to IDLE.
REQ-034 Minimum latency, request to rvalid, SHALL be 2 cycles (request cycle 0, mem_req cycle 1 with gnt, rvalid cycle 2).
REQ-035 mem_rvalid=1 in IDLE or REQ SHALL be ignored (no rvalid forwarded) and SHALL set proto_err.
REQ-036 A request deasserted before its gnt is a requester violation; the arbiter SHALL still complete the registered transaction.
REQ-037 mem_req SHALL be 0 in IDLE and WAIT.

Reset
REQ-038 With rst=1 at a clock edge: state=IDLE, owner=IF, starve counter=0, proto_err=0, registered fields=0.
REQ-039 During and after reset, all outputs SHALL be 0 until the first request.
REQ-040 Reset mid-transaction SHALL abandon the transaction; a later stray mem_rvalid follows REQ-035.

Structure
REQ-041 arb_state_t {IDLE, REQ, WAIT} and arb_owner_t {OWN_IF, OWN_LS} SHALL be declared in rv32_pkg.
REQ-042 Single module with no sub-module; the arbitration and starve counter stay inline.

Verification
REQ-043 IF only: if_addr=0x100, mem_gnt immediate, mem_rdata=0x00000013 one cycle later -> if_gnt in cycle 1, if_rvalid=1 with if_rdata=0x00000013 in cycle 2, busy=0 in cycle 3.
REQ-044 Simultaneous: if_req=1 and ls_req=1 with ls_we=1, ls_be=0xF, ls_addr=0x2000, ls_wdata=0xDEADBEEF -> store issued first (mem_we=1, mem_be=0xF), ls_rvalid on its ack, then the fetch issued back-to-back with no IDLE cycle.
REQ-045 Starvation: ls_req held at 1 and if_req held at 1, STARVE_MAX=4 -> grant order LS,LS,LS,LS,IF,LS...
REQ-046 Stall: mem_gnt=0 for 5 cycles in REQ -> mem_addr/mem_wdata stable, both gnt=0 and busy=1 throughout; grant on cycle 6.
REQ-047 Error and reset: mem_rvalid=1 in IDLE -> proto_err=1 stays set and no rvalid is forwarded; rst=1 while in WAIT -> next cycle IDLE, proto_err=0, mem_req=0.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared types for the instruction-fetch / load-store memory arbiter.
package rv32_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, the load/store port, the downstream memory port and status.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [BE_W-1:0]   ls_be;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              proto_err;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output busy, proto_err
    );

    // Requesters and memory side.
    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  busy, proto_err
    );

endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch, load/store) arbiter onto one single-port memory, one transaction in flight,
// load/store priority with a bounded starvation window for fetch.
module mem_arbiter
    import rv32_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              proto_err_q, proto_err_d;
    logic              we_q, we_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic pending;
    logic if_wins;
    logic arbitrate;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        pending     = bus.if_req | bus.ls_req;
        if_wins     = bus.if_req & (~bus.ls_req | (starve_q == STARVE_LIM));
        arbitrate   = 1'b0;
        state_d     = state_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        we_d        = we_q;
        be_d        = be_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        proto_err_d = proto_err_q | (bus.mem_rvalid & (state_q != WAIT));

        case (state_q)
            IDLE: arbitrate = pending;
            REQ: begin
                if (bus.mem_gnt) state_d = WAIT;
            end
            WAIT: begin
                if (bus.mem_rvalid) begin
                    if (pending) arbitrate = 1'b1;
                    else         state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (arbitrate) begin
            state_d = REQ;
            if (if_wins) begin
                // A fetch is a full-word read.
                owner_d  = OWN_IF;
                starve_d = '0;
                we_d     = 1'b0;
                be_d     = '1;
                addr_d   = bus.if_addr;
                wdata_d  = '0;
            end else begin
                owner_d  = OWN_LS;
                we_d     = bus.ls_we;
                be_d     = bus.ls_be;
                addr_d   = bus.ls_addr;
                wdata_d  = bus.ls_wdata;
                if (!bus.if_req)                starve_d = '0;
                else if (starve_q != STARVE_LIM) starve_d = starve_q + CNT_W'(1);
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            starve_q    <= '0;
            proto_err_q <= 1'b0;
            we_q        <= 1'b0;
            be_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            proto_err_q <= proto_err_d;
            we_q        <= we_d;
            be_q        <= be_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    logic in_req;
    logic rsp;
    assign in_req = (state_q == REQ);
    // Responses are only honoured while waiting; strays elsewhere only raise proto_err.
    assign rsp    = (state_q == WAIT) & bus.mem_rvalid;

    assign bus.if_gnt    = in_req & bus.mem_gnt & (owner_q == OWN_IF);
    assign bus.ls_gnt    = in_req & bus.mem_gnt & (owner_q == OWN_LS);
    assign bus.if_rvalid = rsp & (owner_q == OWN_IF);
    assign bus.ls_rvalid = rsp & (owner_q == OWN_LS);
    assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
    assign bus.ls_rdata  = bus.ls_rvalid ? bus.mem_rdata : '0;

    assign bus.mem_req   = in_req;
    assign bus.mem_we    = we_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.busy      = (state_q != IDLE);
    assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios followed by a randomized run checked against a transaction-level model
// of the arbiter and a reference memory image.
module tb_mem_arbiter;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Memory device (driven from DUT requests) and the independent reference image.
    logic [31:0] mem_dev [logic [31:0]];
    logic [31:0] mem_ref [logic [31:0]];
    logic        gnt_en = 1'b1;
    logic        rsp_en = 1'b1;
    bit          mem_pending = 1'b0;
    logic [31:0] rsp_data = '0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return ~a;
    endfunction

    function automatic logic [31:0] dev_rd(input logic [31:0] a);
        return mem_dev.exists(a) ? mem_dev[a] : dflt(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return mem_ref.exists(a) ? mem_ref[a] : dflt(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    // Closes the current cycle on the memory side, advances one clock, drives the memory inputs.
    task automatic step();
        logic accepted;
        logic responded;
        accepted  = bus.mem_req && bus.mem_gnt;
        responded = bus.mem_rvalid;
        if (mem_pending && responded) mem_pending = 1'b0;
        if (accepted) begin
            mem_pending = 1'b1;
            if (bus.mem_we) begin
                mem_dev[bus.mem_addr] = merge(dev_rd(bus.mem_addr), bus.mem_wdata, bus.mem_be);
                rsp_data = '0;
            end else begin
                rsp_data = dev_rd(bus.mem_addr);
            end
        end
        @(posedge clk);
        #1;
        bus.mem_gnt    = gnt_en;
        bus.mem_rvalid = mem_pending && rsp_en;
        bus.mem_rdata  = (mem_pending && rsp_en) ? rsp_data : '0;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Random-phase model state.
    bit          if_act, ls_act, ls_w, busy_m, issuing_m, own_ls, exp_we, resp, any_req, start;
    logic [31:0] if_a, ls_a, ls_wd, exp_addr, exp_wd, out_data;
    logic [3:0]  ls_b, exp_be;
    int          starve;
    bit          exp_ls [6];
    int          got;

    initial begin
        bus.if_req = 0; bus.if_addr = '0;
        bus.ls_req = 0; bus.ls_we = 0; bus.ls_be = '0; bus.ls_addr = '0; bus.ls_wdata = '0;
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;

        // Reset: every output low.
        for (int i = 0; i < 2; i++) begin
            step(); settle();
            check("reset_ctrl", {bus.if_gnt, bus.if_rvalid, bus.ls_gnt, bus.ls_rvalid,
                                 bus.mem_req, bus.mem_we, bus.busy, bus.proto_err}, 8'h00);
            check("reset_data", |{bus.if_rdata, bus.ls_rdata, bus.mem_be, bus.mem_addr,
                                  bus.mem_wdata}, 1'b0);
        end
        step(); rst = 1'b0; settle();
        check("post_reset_ctrl", {bus.if_gnt, bus.ls_gnt, bus.mem_req, bus.busy}, 4'h0);

        // Fetch only, minimum latency.
        mem_dev[32'h100] = 32'h0000_0013;
        step(); bus.if_req = 1'b1; bus.if_addr = 32'h100; settle();
        check("if_c0_gnt_memreq", {bus.if_gnt, bus.mem_req}, 2'b00);
        step(); settle();
        check("if_c1_gnt_memreq_we", {bus.if_gnt, bus.mem_req, bus.mem_we}, 3'b110);
        check("if_c1_addr", bus.mem_addr, 32'h100);
        step(); bus.if_req = 1'b0; settle();
        check("if_c2_rvalid", {bus.if_rvalid, bus.ls_rvalid, bus.mem_req}, 3'b100);
        check("if_c2_rdata", bus.if_rdata, 32'h13);
        step(); settle();
        check("if_c3_idle", {bus.busy, bus.if_rvalid}, 2'b00);
        check("if_c3_rdata_zero", bus.if_rdata, 32'h0);

        // Simultaneous store and fetch: store first, fetch back-to-back.
        mem_dev[32'h200] = 32'hCAFE_F00D;
        step();
        bus.if_req = 1'b1; bus.if_addr = 32'h200;
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_be = 4'hF;
        bus.ls_addr = 32'h2000; bus.ls_wdata = 32'hDEAD_BEEF;
        settle();
        step(); settle();
        check("sim_c1_gnts_we", {bus.ls_gnt, bus.if_gnt, bus.mem_we, bus.mem_be}, 7'b1011111);
        check("sim_c1_addr_wdata", {bus.mem_addr, bus.mem_wdata}, 64'h0000_2000_DEAD_BEEF);
        step(); bus.ls_req = 1'b0; settle();
        check("sim_c2_ack", {bus.ls_rvalid, bus.if_rvalid, bus.busy}, 3'b101);
        check("sim_c2_ls_rdata", bus.ls_rdata, 32'h0);
        step(); settle();
        check("sim_c3_b2b", {bus.busy, bus.mem_req, bus.if_gnt, bus.mem_we}, 4'b1110);
        check("sim_c3_addr", bus.mem_addr, 32'h200);
        step(); bus.if_req = 1'b0; settle();
        check("sim_c4_if_rvalid", bus.if_rvalid, 1'b1);
        check("sim_c4_if_rdata", bus.if_rdata, 32'hCAFE_F00D);
        check("sim_store_landed", dev_rd(32'h2000), 32'hDEAD_BEEF);
        step(); settle();
        check("sim_c5_idle", bus.busy, 1'b0);

        // Starvation bound: LS x4, then IF, then LS.
        exp_ls[0] = 1; exp_ls[1] = 1; exp_ls[2] = 1; exp_ls[3] = 1; exp_ls[4] = 0; exp_ls[5] = 1;
        step();
        bus.if_req = 1'b1; bus.if_addr = 32'h300;
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h304;
        settle();
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            step(); settle();
            if (bus.if_gnt || bus.ls_gnt) begin
                check($sformatf("starve_grant%0d", got), {bus.ls_gnt, bus.if_gnt},
                      exp_ls[got] ? 2'b10 : 2'b01);
                got++;
            end
        end
        check("starve_grant_count", got, 6);
        step(); bus.if_req = 1'b0; bus.ls_req = 1'b0; settle();
        step(); settle();
        check("starve_drain_idle", bus.busy, 1'b0);

        // Stall in REQ for five cycles.
        gnt_en = 1'b0;
        step();
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_be = 4'h3;
        bus.ls_addr = 32'h40; bus.ls_wdata = 32'h1234_5678;
        settle();
        for (int i = 1; i <= 5; i++) begin
            step(); settle();
            check($sformatf("stall%0d_ctrl", i), {bus.mem_req, bus.busy, bus.if_gnt, bus.ls_gnt},
                  4'b1100);
            check($sformatf("stall%0d_fields", i), {bus.mem_addr, bus.mem_wdata},
                  64'h0000_0040_1234_5678);
        end
        gnt_en = 1'b1;
        step(); settle();
        check("stall_c6_gnt", {bus.ls_gnt, bus.if_gnt}, 2'b10);
        step(); bus.ls_req = 1'b0; settle();
        check("stall_ack", bus.ls_rvalid, 1'b1);
        step(); settle();
        check("stall_idle", bus.busy, 1'b0);

        // Stray response in IDLE.
        step(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h77; settle();
        check("stray_no_fwd", {bus.if_rvalid, bus.ls_rvalid}, 2'b00);
        check("stray_rdata_zero", {bus.if_rdata, bus.ls_rdata}, 64'h0);
        for (int i = 0; i < 3; i++) begin
            step(); settle();
            check($sformatf("proto_err_sticky%0d", i), bus.proto_err, 1'b1);
        end

        // Reset while waiting for a response, then a late stray response.
        rsp_en = 1'b0;
        step(); bus.if_req = 1'b1; bus.if_addr = 32'h100; settle();
        step(); settle();
        step(); bus.if_req = 1'b0; settle();
        check("rst_wait_state", {bus.busy, bus.mem_req}, 2'b10);
        rst = 1'b1;
        step(); rst = 1'b0; settle();
        check("rst_after", {bus.busy, bus.proto_err, bus.mem_req}, 3'b000);
        rsp_en = 1'b1;
        step(); settle();
        check("rst_stray_no_fwd", {bus.if_rvalid, bus.ls_rvalid}, 2'b00);
        step(); settle();
        check("rst_stray_proto_err", bus.proto_err, 1'b1);

        rst = 1'b1;
        step(); rst = 1'b0; settle();
        mem_pending = 1'b0;

        // Randomized traffic against the transaction model.
        if_act = 0; ls_act = 0; busy_m = 0; issuing_m = 0; own_ls = 0; starve = 0;
        if_a = '0; ls_a = '0; ls_wd = '0; ls_b = '0; ls_w = 0;
        exp_addr = '0; exp_we = 0; exp_wd = '0; exp_be = '0; out_data = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            gnt_en = ($urandom_range(0, 3) != 0);
            rsp_en = ($urandom_range(0, 2) != 0);
            step();
            if (!if_act && $urandom_range(0, 2) != 0) begin
                if_act = 1;
                if_a   = 32'h1000 | {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            end
            if (!ls_act && $urandom_range(0, 2) != 0) begin
                ls_act = 1;
                ls_a   = 32'h1000 | {26'h0, 4'($urandom_range(0, 15)), 2'b00};
                ls_w   = 1'($urandom_range(0, 1));
                ls_b   = 4'($urandom_range(0, 15));
                ls_wd  = $urandom;
            end
            bus.if_req = if_act; bus.if_addr = if_a;
            bus.ls_req = ls_act; bus.ls_we = ls_w; bus.ls_be = ls_b;
            bus.ls_addr = ls_a; bus.ls_wdata = ls_wd;
            settle();

            resp = busy_m && !issuing_m && bus.mem_rvalid;
            check("rnd_mem_req", bus.mem_req, issuing_m);
            check("rnd_busy", bus.busy, busy_m);
            check("rnd_gnts", {bus.if_gnt, bus.ls_gnt},
                  (issuing_m && bus.mem_gnt) ? (own_ls ? 2'b01 : 2'b10) : 2'b00);
            check("rnd_rvalids", {bus.if_rvalid, bus.ls_rvalid},
                  resp ? (own_ls ? 2'b01 : 2'b10) : 2'b00);
            check("rnd_if_rdata", bus.if_rdata, (resp && !own_ls) ? out_data : 32'h0);
            check("rnd_ls_rdata", bus.ls_rdata, (resp && own_ls) ? out_data : 32'h0);
            if (issuing_m) begin
                check("rnd_addr", bus.mem_addr, exp_addr);
                check("rnd_we", bus.mem_we, exp_we);
                if (exp_we) check("rnd_store", {bus.mem_be, bus.mem_wdata}, {exp_be, exp_wd});
            end

            any_req = if_act || ls_act;
            start   = 0;
            if (issuing_m) begin
                if (bus.mem_gnt) begin
                    issuing_m = 0;
                    if (own_ls) ls_act = 0;
                    else        if_act = 0;
                    if (exp_we) begin
                        mem_ref[exp_addr] = merge(ref_rd(exp_addr), exp_wd, exp_be);
                        out_data = '0;
                    end else begin
                        out_data = ref_rd(exp_addr);
                    end
                end
            end else if (busy_m) begin
                if (bus.mem_rvalid) begin
                    if (any_req) start = 1;
                    else         busy_m = 0;
                end
            end else if (any_req) begin
                start = 1;
            end
            if (start) begin
                busy_m    = 1;
                issuing_m = 1;
                own_ls    = ls_act && !(if_act && starve == STARVE_MAX);
                if (own_ls) starve = if_act ? ((starve < STARVE_MAX) ? starve + 1 : starve) : 0;
                else        starve = 0;
                exp_addr = own_ls ? ls_a : if_a;
                exp_we   = own_ls && ls_w;
                exp_wd   = ls_wd;
                exp_be   = ls_b;
            end
        end
        check("rnd_proto_err_clear", bus.proto_err, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
